program_rom: RTL and testbench



---
 rtl/program_rom.sv | 144 ++++++++++++++
 tb/tb_program_rom.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/program_rom.sv
// Byte-organised program memory with multi-beat little-endian reads and optional sign extension.
// Define PROGRAM_ROM_WRITE_EN to turn the array into a byte-writable RAM (e.g. for a bootloader).
module program_rom #(
   parameter int    ADDR_WIDTH = 10,
   parameter string INIT_FILE  = "rom.hex",
   parameter int    DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [1:0]            size,
   input  logic                  sign_ext,
   output logic                  busy,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_address,
   input  logic [7:0]            wr_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   generate
      if (DATA_WIDTH != 32) begin : g_bad_width
         $error("program_rom: DATA_WIDTH must be 32");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, READ, LAST, DONE} state_t;

   state_t                  state_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [1:0]              size_reg;
   logic                    sign_reg;
   logic [1:0]              beat_reg;
   logic [1:0]              last_beat_reg;
   logic                    busy_reg;
   logic                    valid_reg;
   logic [31:0]             data_out_reg;
   logic [7:0]              rd_byte_reg;
   logic [31:0]             assembled_word;
   logic [31:0]             extended_word;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [7:0]              mem [DEPTH];

   // Unlisted locations must read as zero.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
   end

   // Beat offset wraps naturally at ADDR_WIDTH bits.
   assign rd_addr = addr_reg + ADDR_WIDTH'(beat_reg);

   // Registered read sits before the write, so a same-edge write to the same byte returns old data.
   always_ff @(posedge clk) begin
`ifdef PROGRAM_ROM_WRITE_EN
      if (wr_en) mem[wr_address] <= wr_data;
`endif
      if (state_reg == READ) rd_byte_reg <= mem[rd_addr];
   end

`ifndef PROGRAM_ROM_WRITE_EN
   logic unused_write_port;
   assign unused_write_port = ^{wr_en, wr_address, wr_data};
`endif

   // Each lane captures the byte read on the previous beat; the final lane comes straight from rd_byte_reg.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               lane_reg <= 8'h00;
            end else if (state_reg == IDLE && req) begin
               lane_reg <= 8'h00;
            end else if (state_reg == READ && beat_reg != 2'd0 && (beat_reg - 2'd1) == 2'(gi)) begin
               lane_reg <= rd_byte_reg;
            end
         end
         assign assembled_word[8*gi +: 8] = (last_beat_reg == 2'(gi)) ? rd_byte_reg : lane_reg;
      end
   endgenerate

   always_comb begin
      extended_word = assembled_word;
      case (size_reg)
         2'd0:    extended_word = {{24{sign_reg & assembled_word[7]}}, assembled_word[7:0]};
         2'd1:    extended_word = {{16{sign_reg & assembled_word[15]}}, assembled_word[15:0]};
         default: extended_word = assembled_word;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         size_reg      <= 2'd0;
         sign_reg      <= 1'b0;
         beat_reg      <= 2'd0;
         last_beat_reg <= 2'd0;
         busy_reg      <= 1'b0;
         valid_reg     <= 1'b0;
         data_out_reg  <= 32'h0;
      end else begin
         case (state_reg)
            IDLE: begin
               valid_reg <= 1'b0;
               if (req) begin
                  addr_reg      <= address;
                  size_reg      <= size;
                  sign_reg      <= sign_ext;
                  last_beat_reg <= (size == 2'd0) ? 2'd0 : (size == 2'd1) ? 2'd1 : 2'd3;
                  beat_reg      <= 2'd0;
                  busy_reg      <= 1'b1;
                  state_reg     <= READ;
               end
            end
            READ: begin
               beat_reg <= beat_reg + 2'd1;
               if (beat_reg == last_beat_reg) state_reg <= LAST;
            end
            LAST: begin
               data_out_reg <= extended_word;
               valid_reg    <= 1'b1;
               busy_reg     <= 1'b0;
               state_reg    <= DONE;
            end
            // Valid cycle: req is deliberately not sampled here.
            DONE: begin
               valid_reg <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy     = busy_reg;
   assign valid    = valid_reg;
   assign data_out = data_out_reg;

endmodule

// File: tb/tb_program_rom.sv
// Directed bench for program_rom: table of single reads plus reset-abort, back-to-back and write sequences.
module tb_program_rom;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          req;
   logic [AW-1:0] address;
   logic [1:0]    size;
   logic          sign_ext;
   logic          busy;
   logic          valid;
   logic [31:0]   data_out;
   logic          wr_en;
   logic [AW-1:0] wr_address;
   logic [7:0]    wr_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   program_rom #(.ADDR_WIDTH(AW), .INIT_FILE(""), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .req(req), .address(address), .size(size),
      .sign_ext(sign_ext), .busy(busy), .valid(valid), .data_out(data_out),
      .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } init_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [1:0]    size;
      logic          sx;
      logic [31:0]   exp;
   } vec_t;

   init_t image [14];
   vec_t  vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input string name, input logic [AW-1:0] a, input logic [1:0] s,
                          input logic se, input logic [31:0] exp);
      int n;
      int edges;
      int busy_cnt;
      bit got;
      n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      address  = a;
      size     = s;
      sign_ext = se;
      req      = 1'b1;
      tick();
      req      = 1'b0;
      busy_cnt = busy ? 1 : 0;
      // Changing the request inputs mid-read must have no effect.
      address  = ~a;
      size     = ~s;
      sign_ext = ~se;
      edges    = 0;
      got      = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         edges++;
         if (valid) got = 1'b1;
         else if (busy) busy_cnt++;
      end
      check({name, " latency"}, 32'(edges), 32'(n + 1));
      check({name, " busy cycles"}, 32'(busy_cnt), 32'(n + 1));
      check({name, " busy at valid"}, {31'd0, busy}, 32'd0);
      check({name, " data"}, data_out, exp);
      tick();
      check({name, " valid pulse"}, {31'd0, valid}, 32'd0);
      check({name, " data held"}, data_out, exp);
   endtask

   initial begin
      int vcount;
      int first_off;
      int second_off;
      bit got;

      image = '{
         '{10'h000, 8'hb7}, '{10'h001, 8'h02}, '{10'h002, 8'h00}, '{10'h003, 8'h00},
         '{10'h004, 8'h78}, '{10'h005, 8'h56}, '{10'h006, 8'h34}, '{10'h007, 8'h12},
         '{10'h008, 8'h89}, '{10'h010, 8'ha5}, '{10'h012, 8'h00}, '{10'h013, 8'h80},
         '{10'h3fe, 8'hcd}, '{10'h3ff, 8'h34}
      };
      vecs = '{
         '{10'h000, 2'd2, 1'b0, 32'h000002b7},
         '{10'h008, 2'd0, 1'b1, 32'hffffff89},
         '{10'h008, 2'd0, 1'b0, 32'h00000089},
         '{10'h3ff, 2'd1, 1'b1, 32'hffffb734},
         '{10'h3ff, 2'd1, 1'b0, 32'h0000b734},
         '{10'h004, 2'd3, 1'b1, 32'h12345678},
         '{10'h3fe, 2'd2, 1'b0, 32'h02b734cd},
         '{10'h012, 2'd1, 1'b1, 32'hffff8000},
         '{10'h013, 2'd0, 1'b1, 32'hffffff80},
         '{10'h005, 2'd1, 1'b1, 32'h00003456},
         '{10'h3ff, 2'd2, 1'b1, 32'h0002b734}
      };

      reset = 1'b1; req = 1'b0; address = '0; size = 2'd0; sign_ext = 1'b0;
      wr_en = 1'b0; wr_address = '0; wr_data = 8'h00;
      #1;
`ifdef PROGRAM_ROM_WRITE_EN
      foreach (image[i]) begin
         wr_en = 1'b1; wr_address = image[i].addr; wr_data = image[i].data;
         tick();
      end
      wr_en = 1'b0;
`else
      foreach (image[i]) dut.mem[image[i].addr] = image[i].data;
      tick();
`endif
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset valid", {31'd0, valid}, 32'd0);
      check("reset data_out", data_out, 32'd0);
      reset = 1'b0;
      tick();
      check("idle busy", {31'd0, busy}, 32'd0);

      foreach (vecs[i])
         do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].size, vecs[i].sx, vecs[i].exp);

      // Abort a word read after two beats.
      address = 10'h004; size = 2'd2; sign_ext = 1'b0; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort valid", {31'd0, valid}, 32'd0);
      check("abort data_out", data_out, 32'd0);
      #2 reset = 1'b0;
      tick();
      do_read("post-reset word", 10'h004, 2'd2, 1'b0, 32'h12345678);

      // Sustained req: second request must land 7 cycles after the first.
      address = 10'h000; size = 2'd2; sign_ext = 1'b0; req = 1'b1;
      tick();
      vcount = 0; first_off = -1; second_off = -1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (valid) begin
            vcount++;
            if (vcount == 1) first_off = i;
            if (vcount == 2) second_off = i;
            check($sformatf("b2b data @%0d", i), data_out, 32'h000002b7);
         end
      end
      req = 1'b0;
      check("b2b valid count", 32'(vcount), 32'd2);
      check("b2b first offset", 32'(first_off), 32'd5);
      check("b2b second offset", 32'(second_off), 32'd12);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (valid) got = 1'b1;
      end
      check("b2b drain", {31'd0, got}, 32'd1);
      tick();

      wr_en = 1'b1; wr_address = 10'h010; wr_data = 8'h5a;
      tick();
      wr_en = 1'b0;
`ifdef PROGRAM_ROM_WRITE_EN
      do_read("write-then-read", 10'h010, 2'd0, 1'b0, 32'h0000005a);
`else
      do_read("write-ignored", 10'h010, 2'd0, 1'b0, 32'h000000a5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
